mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single shared instruction/data memory port of the multicycle core. Two requesters, the core's memory stage and a program loader/debug port, compete for one fixed-latency synchronous memory. The block grants one requester at a time, drives the memory, counts out the access latency and returns a one-cycle response to the owner. It sits between the core's memory interface and the memory model and produces the core stall.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1..15
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- core_req / ldr_req  input  1  access request; held until the matching rvalid
- core_we / ldr_we  input  1  1 = write, 0 = read
- core_addr / ldr_addr  input  ADDR_W  byte address
- core_wdata / ldr_wdata  input  DATA_W  write data
- core_gnt / ldr_gnt  output  1  one-cycle pulse: request accepted and issued
- core_rvalid / ldr_rvalid  output  1  one-cycle pulse: access complete
- core_rdata / ldr_rdata  output  DATA_W  read data, valid with rvalid; 0 for writes
- core_stall  output  1  combinational: core_req & ~core_rvalid
- mem_en  output  1  memory access strobe, one cycle per access
- mem_we  output  1  write enable, qualified by mem_en
- mem_addr  output  ADDR_W  address, qualified by mem_en
- mem_wdata  output  DATA_W  write data, qualified by mem_en
- mem_rdata  input  DATA_W  read data, valid MEM_LAT cycles after mem_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, select an owner, latch owner/we/addr/wdata, and go to ISSUE. Otherwise stay.
- ISSUE: mem_en=1, mem_we/addr/wdata come from the latch, the owner's gnt=1, and the latency counter loads MEM_LAT-1. Go to WAIT, or to RESP directly when MEM_LAT=1.
- WAIT: decrement the counter. When the counter is 0, capture mem_rdata (reads only) and go to RESP.
- RESP: the owner's rvalid=1 and its rdata=captured value (0 for writes). Go to IDLE unconditionally. req inputs are ignored in RESP.
- Selection is done by sub-module arb_pick. The behaviour for simultaneous requests is set by the macro below.
- A requester dropping req mid-access is a protocol violation. The access still completes and rvalid is still issued.
- The non-owner's gnt, rvalid and rdata are always 0.
- Counter width: $clog2(MEM_LAT+1); no arithmetic wider than that.

## Timing
- A request sampled high in IDLE at cycle T gives gnt and mem_en in T+1, and rvalid in T+1+MEM_LAT.
- Back-to-back accesses: the next earliest mem_en is at T+3+MEM_LAT. Port throughput is one access per MEM_LAT+2 cycles.
- Reset (async assert): state=IDLE; all outputs are 0, including mem_en, mem_we, mem_addr, mem_wdata, gnt, rvalid and rdata. The latches and counter clear, and last_owner=LDR.
- Reset asserted mid-access abandons the access. No rvalid is issued, then or after release.
- The first IDLE decision happens on the first rising edge after rst_n deasserts.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both requests are high in IDLE, the requester other than last_owner wins. last_owner updates on every grant. From reset the first tie goes to the core.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, with the loader always beating the core. last_owner is not implemented.
- Single-requester behaviour is identical in both builds.

## Structure
- Package mc_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner encoding (OWN_CORE=0, OWN_LDR=1);
  - constants MEM_LAT_MIN=1 and MEM_LAT_MAX=15.
- Sub-module arb_pick is combinational. Inputs: core_req, ldr_req, last_owner. Outputs: valid and owner. The ARB_ROUND_ROBIN_EN logic lives only in arb_pick.
- The FSM, latches, counter and response path stay in mem_port_arbiter.

## Test plan
- Core read, MEM_LAT=2, addr 0x40, memory returns 0xDEADBEEF:
  - req at T;
  - gnt and mem_en at T+1 with mem_addr=0x40 and mem_we=0;
  - core_rvalid at T+3 with core_rdata=0xDEADBEEF;
  - core_stall high T..T+2 and low at T+3.
- Loader write 0x1234 to 0x80: mem_en=1, mem_we=1 and mem_wdata=0x1234 for exactly one cycle; ldr_rvalid one cycle with ldr_rdata=0; core outputs stay 0.
- Both requesters held high for 4 accesses:
  - with ARB_ROUND_ROBIN_EN, grant order is CORE, LDR, CORE, LDR;
  - without it, the loader gets all 4 grants while the core stalls throughout.
- MEM_LAT=1 and MEM_LAT=15: rvalid arrives exactly MEM_LAT cycles after mem_en in both cases; gap between successive mem_en pulses is MEM_LAT+2.
- rst_n pulsed low in WAIT: all outputs go to 0 immediately, no rvalid follows, and a fresh request after release completes normally.
- Core drops req in WAIT: core_rvalid is still pulsed once; the arbiter returns to IDLE and no spurious second grant occurs.

Source files
------------

// File: rtl/mc_arb_pkg.sv
// rtl/mc_arb_pkg.sv - shared types and limits for the memory port arbiter
package mc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_LDR  = 1'b1
    } owner_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    function automatic int clamp_lat(input int lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - owner selection for the shared memory port
// ARB_ROUND_ROBIN_EN selects alternating ties; otherwise the loader always wins.
module arb_pick
    import mc_arb_pkg::*;
(
    input  logic   core_req,
    input  logic   ldr_req,
    input  owner_t last_owner,
    output logic   valid,
    output owner_t owner
);

    assign valid = core_req | ldr_req;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        owner = OWN_CORE;
        if (core_req && ldr_req) begin
            owner = (last_owner == OWN_CORE) ? OWN_LDR : OWN_CORE;
        end else if (ldr_req) begin
            owner = OWN_LDR;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign owner = ldr_req ? OWN_LDR : OWN_CORE;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core/loader arbiter and latency sequencer for one memory port
// Optional build macro: ARB_ROUND_ROBIN_EN (alternate owners on simultaneous requests).
module mem_port_arbiter
    import mc_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT   = clamp_lat(MEM_LAT);
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t        state_q, state_d;
    owner_t            owner_q;
    owner_t            last_owner;
    owner_t            pick_owner;
    logic              pick_valid;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              latch_en;
    logic              capture;
    logic              issue;
    logic              resp;

    arb_pick u_pick (
        .core_req   (core_req),
        .ldr_req    (ldr_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .owner      (pick_owner)
    );

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWN_LDR;
        end else if (state_q == ISSUE) begin
            last_owner <= owner_q;
        end
    end
`else
    assign last_owner = OWN_LDR;
`endif

    // WAIT runs LAT-1 cycles: the decremented count hitting zero marks the data cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    latch_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = CNT_LOAD;
                if (LAT == 1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_d == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                owner_q <= pick_owner;
                we_q    <= (pick_owner == OWN_LDR) ? ldr_we    : core_we;
                addr_q  <= (pick_owner == OWN_LDR) ? ldr_addr  : core_addr;
                wdata_q <= (pick_owner == OWN_LDR) ? ldr_wdata : core_wdata;
            end
            if (capture) begin
                rdata_q <= we_q ? '0 : mem_rdata;
            end
        end
    end

    assign issue = (state_q == ISSUE);
    assign resp  = (state_q == RESP);

    // Memory-side fields are gated so the bus reads as zero outside the strobe cycle.
    assign mem_en    = issue;
    assign mem_we    = issue & we_q;
    assign mem_addr  = issue ? addr_q  : '0;
    assign mem_wdata = issue ? wdata_q : '0;

    assign core_gnt    = issue & (owner_q == OWN_CORE);
    assign ldr_gnt     = issue & (owner_q == OWN_LDR);
    assign core_rvalid = resp  & (owner_q == OWN_CORE);
    assign ldr_rvalid  = resp  & (owner_q == OWN_LDR);
    assign core_rdata  = core_rvalid ? rdata_q : '0;
    assign ldr_rdata   = ldr_rvalid  ? rdata_q : '0;
    assign core_stall  = core_req & ~core_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at MEM_LAT 2, 1 and 15
module tb_mem_port_arbiter;
    import mc_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NI = 3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    endfunction

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | i);
    endfunction

    typedef struct {
        logic          ldr;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [NI-1:0] core_req, core_we, ldr_req, ldr_we;
    logic [NI-1:0] core_gnt, ldr_gnt, core_rvalid, ldr_rvalid, core_stall, mem_en, mem_we;
    logic [AW-1:0] core_addr [NI];
    logic [AW-1:0] ldr_addr  [NI];
    logic [AW-1:0] mem_addr  [NI];
    logic [DW-1:0] core_wdata [NI];
    logic [DW-1:0] ldr_wdata  [NI];
    logic [DW-1:0] core_rdata [NI];
    logic [DW-1:0] ldr_rdata  [NI];
    logic [DW-1:0] mem_wdata  [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = lat_of(g);
        logic [DW-1:0] mem [64];
        logic [63:0]   wr_v;
        logic [DW-1:0] pipe [16];
        logic [DW-1:0] rd_now;
        logic [DW-1:0] rd;
        logic [5:0]    idx;

        assign idx    = mem_addr[g][7:2];
        assign rd_now = wr_v[idx] ? mem[idx] : init_word(int'(idx));
        assign rd     = (L == 1) ? rd_now : pipe[(L >= 2) ? L - 2 : 0];

        always @(posedge clk) begin
            if (!rst_n) begin
                wr_v <= '0;
            end else if (mem_en[g] && mem_we[g]) begin
                mem[idx]  <= mem_wdata[g];
                wr_v[idx] <= 1'b1;
            end
            pipe[0] <= rd_now;
            for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
        end

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .core_req    (core_req[g]),
            .core_we     (core_we[g]),
            .core_addr   (core_addr[g]),
            .core_wdata  (core_wdata[g]),
            .core_gnt    (core_gnt[g]),
            .core_rvalid (core_rvalid[g]),
            .core_rdata  (core_rdata[g]),
            .core_stall  (core_stall[g]),
            .ldr_req     (ldr_req[g]),
            .ldr_we      (ldr_we[g]),
            .ldr_addr    (ldr_addr[g]),
            .ldr_wdata   (ldr_wdata[g]),
            .ldr_gnt     (ldr_gnt[g]),
            .ldr_rvalid  (ldr_rvalid[g]),
            .ldr_rdata   (ldr_rdata[g]),
            .mem_en      (mem_en[g]),
            .mem_we      (mem_we[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_rdata   (rd)
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input int i);
        chk("rst_core_gnt", core_gnt[i], 0);
        chk("rst_ldr_gnt", ldr_gnt[i], 0);
        chk("rst_core_rvalid", core_rvalid[i], 0);
        chk("rst_ldr_rvalid", ldr_rvalid[i], 0);
        chk("rst_core_rdata", core_rdata[i], 0);
        chk("rst_ldr_rdata", ldr_rdata[i], 0);
        chk("rst_mem_en", mem_en[i], 0);
        chk("rst_mem_we", mem_we[i], 0);
        chk("rst_mem_addr", mem_addr[i], 0);
        chk("rst_mem_wdata", mem_wdata[i], 0);
        chk("rst_core_stall", core_stall[i], 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // One access checked cycle by cycle from request to response.
    task automatic do_txn(input int i, input vec_t v);
        int L = lat_of(i);
        @(posedge clk); #1;
        if (v.ldr) begin
            ldr_req[i] = 1'b1; ldr_we[i] = v.we; ldr_addr[i] = v.addr; ldr_wdata[i] = v.wdata;
        end else begin
            core_req[i] = 1'b1; core_we[i] = v.we; core_addr[i] = v.addr; core_wdata[i] = v.wdata;
        end
        @(negedge clk);
        chk("stall_at_req", core_stall[i], !v.ldr);
        chk("no_gnt_at_req", core_gnt[i] | ldr_gnt[i], 0);
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("owner_gnt", v.ldr ? ldr_gnt[i] : core_gnt[i], 1);
                chk("other_gnt", v.ldr ? core_gnt[i] : ldr_gnt[i], 0);
                chk("mem_en_issue", mem_en[i], 1);
                chk("mem_we_issue", mem_we[i], v.we);
                chk("mem_addr_issue", mem_addr[i], v.addr);
                if (v.we) chk("mem_wdata_issue", mem_wdata[i], v.wdata);
            end else begin
                chk("mem_en_once", mem_en[i], 0);
                chk("mem_we_once", mem_we[i], 0);
                chk("gnt_once", core_gnt[i] | ldr_gnt[i], 0);
            end
            if (k <= L) begin
                chk("rvalid_early", core_rvalid[i] | ldr_rvalid[i], 0);
                chk("stall_wait", core_stall[i], !v.ldr);
            end else begin
                chk("owner_rvalid", v.ldr ? ldr_rvalid[i] : core_rvalid[i], 1);
                chk("owner_rdata", v.ldr ? ldr_rdata[i] : core_rdata[i], v.exp_rdata);
                chk("other_rvalid", v.ldr ? core_rvalid[i] : ldr_rvalid[i], 0);
                chk("other_rdata", v.ldr ? core_rdata[i] : ldr_rdata[i], 0);
                chk("stall_resp", core_stall[i], 0);
            end
        end
        @(posedge clk); #1;
        core_req[i] = 1'b0;
        ldr_req[i]  = 1'b0;
    endtask

    task automatic gap_test(input int i);
        int L = lat_of(i);
        int en_c[$];
        int rv_c[$];
        @(posedge clk); #1;
        core_req[i] = 1'b1; core_we[i] = 1'b0; core_addr[i] = 32'h48;
        for (int n = 0; n < 100 && rv_c.size() < 2; n++) begin
            @(negedge clk);
            if (mem_en[i]) en_c.push_back(cyc);
            if (core_rvalid[i]) rv_c.push_back(cyc);
        end
        @(posedge clk); #1;
        core_req[i] = 1'b0;
        chk("gap_rvalid_count", rv_c.size(), 2);
        chk("gap_en_count", en_c.size(), 2);
        if (en_c.size() == 2 && rv_c.size() == 2) begin
            chk("lat_first", rv_c[0] - en_c[0], L);
            chk("lat_second", rv_c[1] - en_c[1], L);
            chk("en_gap", en_c[1] - en_c[0], L + 2);
        end
    endtask

    // Transaction-level reference: tracks one outstanding access and a shadow memory.
    logic          mon_en = 1'b0;
    logic          busy = 1'b0;
    logic          pend_owner = 1'b0;
    logic          last_owner_m = 1'b1;
    logic          p_core = 1'b0, p_ldr = 1'b0;
    int            issue_cyc = 0, last_issue = -1, n_gnt = 0, n_rsp = 0;
    logic [DW-1:0] exp_d = '0;
    logic [DW-1:0] ref_mem [64];

    always @(negedge clk) begin
        if (mon_en) begin
            logic          own, tie_exp;
            logic [AW-1:0] a;
            logic          w;
            chk("stall_fn", core_stall[0], core_req[0] & ~core_rvalid[0]);
            if (core_gnt[0] || ldr_gnt[0]) begin
                own = ldr_gnt[0];
`ifdef ARB_ROUND_ROBIN_EN
                tie_exp = ~last_owner_m;
`else
                tie_exp = 1'b1;
`endif
                chk("gnt_excl", core_gnt[0] & ldr_gnt[0], 0);
                chk("gnt_with_en", mem_en[0], 1);
                chk("gnt_while_busy", busy, 0);
                chk("gnt_had_req", own ? p_ldr : p_core, 1);
                if (p_core && p_ldr) chk("tie_winner", own, tie_exp);
                if (last_issue >= 0) chk("issue_spacing", (cyc - last_issue) >= 4, 1);
                a = own ? ldr_addr[0] : core_addr[0];
                w = own ? ldr_we[0] : core_we[0];
                chk("rnd_mem_addr", mem_addr[0], a);
                chk("rnd_mem_we", mem_we[0], w);
                if (w) begin
                    chk("rnd_mem_wdata", mem_wdata[0], own ? ldr_wdata[0] : core_wdata[0]);
                    ref_mem[a[7:2]] = own ? ldr_wdata[0] : core_wdata[0];
                    exp_d = '0;
                end else begin
                    exp_d = ref_mem[a[7:2]];
                end
                busy = 1'b1; pend_owner = own; issue_cyc = cyc; last_issue = cyc;
                last_owner_m = own; n_gnt++;
            end else begin
                chk("en_without_gnt", mem_en[0], 0);
            end
            if (core_rvalid[0] || ldr_rvalid[0]) begin
                chk("rvalid_excl", core_rvalid[0] & ldr_rvalid[0], 0);
                chk("rvalid_pending", busy, 1);
                chk("rvalid_owner", ldr_rvalid[0], pend_owner);
                chk("rvalid_latency", cyc - issue_cyc, 2);
                chk("rnd_rdata", ldr_rvalid[0] ? ldr_rdata[0] : core_rdata[0], exp_d);
                busy = 1'b0; n_rsp++;
            end
            chk("rdata_quiet", (core_rvalid[0] ? 32'h0 : core_rdata[0]) | (ldr_rvalid[0] ? 32'h0 : ldr_rdata[0]), 0);
            p_core = core_req[0];
            p_ldr  = ldr_req[0];
        end
    end

    task automatic drive(input int r, input int n);
        logic got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if (r == 1) begin
                ldr_req[0] = 1'b1; ldr_we[0] = 1'($urandom_range(0, 1));
                ldr_addr[0] = AW'((32 + $urandom_range(0, 7)) << 2); ldr_wdata[0] = $urandom;
            end else begin
                core_req[0] = 1'b1; core_we[0] = 1'($urandom_range(0, 1));
                core_addr[0] = AW'((32 + $urandom_range(0, 7)) << 2); core_wdata[0] = $urandom;
            end
            got = 1'b0;
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge clk);
                got = (r == 1) ? ldr_rvalid[0] : core_rvalid[0];
            end
            chk("drv_completion", got, 1);
            @(posedge clk); #1;
            if (r == 1) ldr_req[0] = 1'b0; else core_req[0] = 1'b0;
        end
    endtask

    initial begin
        vec_t tbl [6];
        logic [3:0] order, exp_order;
        logic       exp_all_stall;
        int         ng, nrv, st_cyc, tot, rv_cnt, g_cnt;

        tbl[0] = '{ldr: 1'b0, we: 1'b0, addr: 32'h40, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
        tbl[1] = '{ldr: 1'b1, we: 1'b1, addr: 32'h80, wdata: 32'h1234,      exp_rdata: 32'h0};
        tbl[2] = '{ldr: 1'b0, we: 1'b0, addr: 32'h80, wdata: 32'h0,         exp_rdata: 32'h1234};
        tbl[3] = '{ldr: 1'b1, we: 1'b0, addr: 32'h44, wdata: 32'h0,         exp_rdata: 32'hC0DE_0011};
        tbl[4] = '{ldr: 1'b0, we: 1'b1, addr: 32'h44, wdata: 32'hA5A5_5A5A, exp_rdata: 32'h0};
        tbl[5] = '{ldr: 1'b1, we: 1'b0, addr: 32'h44, wdata: 32'h0,         exp_rdata: 32'hA5A5_5A5A};
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b1010;
        exp_all_stall = 1'b0;
`else
        exp_order = 4'b1111;
        exp_all_stall = 1'b1;
`endif

        rst_n = 1'b0;
        core_req = '0; core_we = '0; ldr_req = '0; ldr_we = '0;
        for (int i = 0; i < NI; i++) begin
            core_addr[i] = '0; core_wdata[i] = '0; ldr_addr[i] = '0; ldr_wdata[i] = '0;
        end
        #1 check_zero(0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int t = 0; t < 6; t++) do_txn(0, tbl[t]);
        do_txn(1, tbl[0]);
        do_txn(2, tbl[0]);

        // Core abandons its request while the access is in flight.
        @(posedge clk); #1;
        core_req[0] = 1'b1; core_we[0] = 1'b0; core_addr[0] = 32'h44;
        @(negedge clk); @(negedge clk);
        chk("drop_gnt", core_gnt[0], 1);
        @(posedge clk); #1 core_req[0] = 1'b0;
        rv_cnt = 0; g_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            rv_cnt += int'(core_rvalid[0]);
            g_cnt  += int'(core_gnt[0] | ldr_gnt[0]);
        end
        chk("drop_rvalid_once", rv_cnt, 1);
        chk("drop_no_regrant", g_cnt, 0);

        // Reset in WAIT abandons the access.
        @(posedge clk); #1;
        core_req[0] = 1'b1; core_we[0] = 1'b0; core_addr[0] = 32'h40;
        @(negedge clk); @(negedge clk);
        chk("rstw_gnt", core_gnt[0], 1);
        @(posedge clk); #1;
        core_req[0] = 1'b0; rst_n = 1'b0;
        #1 check_zero(0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        rv_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            rv_cnt += int'(core_rvalid[0] | ldr_rvalid[0] | core_gnt[0] | ldr_gnt[0]);
        end
        chk("rstw_no_rvalid", rv_cnt, 0);
        do_txn(0, tbl[0]);

        // Both requesters held for four accesses.
        pulse_reset();
        @(posedge clk); #1;
        core_req[0] = 1'b1; core_we[0] = 1'b0; core_addr[0] = 32'h40;
        ldr_req[0]  = 1'b1; ldr_we[0]  = 1'b0; ldr_addr[0]  = 32'h44;
        order = '0; ng = 0; nrv = 0; st_cyc = 0; tot = 0;
        for (int n = 0; n < 100 && nrv < 4; n++) begin
            @(negedge clk);
            tot++;
            if (core_stall[0]) st_cyc++;
            if (core_gnt[0] | ldr_gnt[0]) begin
                if (ng < 4) order[ng] = ldr_gnt[0];
                ng++;
            end
            if (core_rvalid[0] | ldr_rvalid[0]) nrv++;
        end
        @(posedge clk); #1;
        core_req[0] = 1'b0; ldr_req[0] = 1'b0;
        chk("tie_grant_count", ng, 4);
        chk("tie_order", order, exp_order);
        chk("tie_stall_all", st_cyc == tot, exp_all_stall);

        gap_test(0);
        gap_test(1);
        gap_test(2);

        // Randomised traffic against the reference model.
        pulse_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        last_owner_m = 1'b1; last_issue = -1; busy = 1'b0; n_gnt = 0; n_rsp = 0;
        p_core = 1'b0; p_ldr = 1'b0;
        mon_en = 1'b1;
        fork
            drive(0, 25);
            drive(1, 25);
        join
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        chk("rnd_grants", n_gnt, 50);
        chk("rnd_responses", n_rsp, 50);
        chk("rnd_idle_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
